memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
//   Responder (memory) end of the CPU address/data path. It accepts one access request
//   per handshake and serves byte, halfword or word reads and writes.
//   Requests are addressed with the 8-bit address selected by the IorD multiplexer.
//   Storage is a 256-byte big-endian array, moved one byte per cycle.
//   The block models a slow memory for the multicycle datapath and returns a response
//   through a valid/ready handshake.
// PARAMETERS
//   ADDR_WIDTH   8   byte-address width; the array holds 2**ADDR_WIDTH bytes
//   DATA_WIDTH   32  data bus width; fixed at 32
//   WAIT_CYCLES  1   idle cycles between request acceptance and the first byte transfer (0..15)
// PORTS
//   clock      in   1   single clock; all logic is on the rising edge
//   reset      in   1   synchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   block can accept a request (high only in IDLE)
//   req_write  in   1   1 = write, 0 = read
//   req_size   in   2   0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_addr   in   8   byte address (from MuxIorD result)
//   req_wdata  in   32  write data; right-justified for byte and half accesses
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   consumer accepts the response
//   rsp_rdata  out  32  read data, zero-extended into the low bytes; 0 for writes and errors
//   rsp_err    out  1   misaligned address or reserved size; no access performed
// BEHAVIOUR
//   - Reset (reset == 0 at a clock edge):
//       - state goes to IDLE; req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
//       - The byte array is not cleared.
//   - FSM states: IDLE -> WAIT -> XFER -> RESP -> IDLE.
//       - IDLE: a request is accepted on an edge where req_valid & req_ready.
//         The block latches write, size, addr and wdata; later input changes are ignored.
//       - Error check at acceptance: half with addr[0] != 0, word with addr[1:0] != 0,
//         or size == 3 goes straight to RESP with rsp_err = 1 and rsp_rdata = 0.
//         Memory is untouched.
//       - WAIT: stays WAIT_CYCLES cycles. With WAIT_CYCLES = 0 the WAIT state is skipped.
//       - XFER: moves one byte per cycle, N = 1, 2 or 4 cycles by size.
//         The byte counter runs 0..N-1 and the address is addr + counter, modulo 256.
//         Aligned accesses never wrap.
//       - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
//         The state then returns to IDLE on that edge.
//   - Byte order is big-endian. Byte k of an access goes to address addr + k.
//       - Word: mem[A] = data[31:24] ... mem[A+3] = data[7:0].
//       - Half: mem[A] = data[15:8], mem[A+1] = data[7:0].
//       - Byte: mem[A] = data[7:0].
//       - Reads assemble the same mapping. Unused upper bits are 0; sign extension belongs to the CPU.
//   - Latency: a request accepted at edge T drives rsp_valid from edge T + 1 + WAIT_CYCLES + N.
//     Errors drive rsp_valid from edge T + 1.
//   - Each write byte commits at its own XFER edge.
//   - A read of an address written by the previous request returns the new data.
//   - req_ready is low from acceptance until the response handshake completes.
//       - A request arriving in the same cycle as the response handshake is not accepted.
//       - That request is accepted at the next edge, in IDLE.
//   - rsp_ready held low stalls indefinitely. No response is dropped or overwritten.
//   - Reset mid-operation aborts the access. Bytes already committed stay written;
//     remaining bytes are not written. No response is issued.
// STRUCTURE
//   - Shared package mem_pkg holds:
//       - size encodings: SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2
//       - state encodings: ST_IDLE, ST_WAIT, ST_XFER, ST_RESP
//       - function bytes_for_size()
//   - Sub-module mem_byte_array: 2**ADDR_WIDTH x 8, single port.
//     Combinational read, synchronous write with a write enable.
//   - Top level holds the FSM, the wait and byte counters, the request latches and the rdata shift register.
// TESTING
//   1. Word write 0xDEADBEEF @0x10, then word read @0x10, then byte read @0x11.
//      -> rdata 0xDEADBEEF, then 0x000000AD, err = 0.
//      With WAIT_CYCLES = 1, rsp_valid rises 6 cycles after acceptance.
//   2. Word write 0x00000000 @0x20, half write 0x1234 @0x22, word read @0x20.
//      -> rdata 0x00001234.
//   3. Word read @0x13, half write @0x21, size 3 @0x00.
//      -> each gives rsp_err = 1 and rdata 0 one cycle after acceptance; memory is unchanged.
//   4. Word read with rsp_ready held low 5 cycles, and a new req_valid asserted meanwhile.
//      -> rsp_valid and rdata stay stable and req_ready stays 0.
//      -> The new request is accepted on the cycle after the handshake.
//   5. Word write 0xAABBCCDD @0xFC, with reset asserted after 2 XFER edges, then a word read @0xFC.
//      -> outputs are at reset values.
//      -> The read gives 0xAABB followed by the prior contents of 0xFE and 0xFF.
//   6. WAIT_CYCLES = 0 instance: byte read.
//      -> rsp_valid 2 cycles after acceptance.
//      Back-to-back byte writes @0xFF then @0x00 complete correctly with no wrap corruption.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and size helpers.
// Imported by the responder top and its testbench.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Reserved size reports zero bytes; it never reaches XFER.
    function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            SIZE_WORD: n = 3'd4;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lsb);
        return (size == SIZE_RSVD)
            || ((size == SIZE_HALF) && addr_lsb[0])
            || ((size == SIZE_WORD) && (addr_lsb != 2'b00));
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bus between the CPU datapath (master) and the memory responder (slave).
interface memory_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/memory_responder_byte_array.sv
// Single-port byte storage: combinational read, write on the rising edge when enabled.
// Contents are never reset.
module mem_byte_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);
    logic [7:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/memory_responder.sv
// Slow big-endian memory responder: one request per handshake, one byte moved per cycle.
// rsp_valid rises 1 + WAIT_CYCLES + N edges after acceptance (1 edge for errors) and holds until taken.
module memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    memory_responder_if.slave  bus
);
    localparam bit SKIP_WAIT = (WAIT_CYCLES == 0);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_write;
    logic [1:0]            r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [3:0]            r_wait_cnt;
    logic [1:0]            r_byte_cnt;
    logic                  r_err;
    logic                  r_rsp_valid;

    logic                  w_req_ready;
    logic                  w_bad;
    logic                  w_mem_we;
    logic [7:0]            w_mem_rdata;
    logic [ADDR_WIDTH-1:0] w_xfer_addr;
    logic [DATA_WIDTH-1:0] w_wdata_aligned;

    assign w_bad       = is_bad_access(bus.req_size, bus.req_addr[1:0]);
    assign w_xfer_addr = r_addr + ADDR_WIDTH'(r_byte_cnt);

    // Left-justify write data so the next big-endian byte is always in the top lane.
    always_comb begin
        w_wdata_aligned = bus.req_wdata;
        case (bus.req_size)
            SIZE_BYTE: w_wdata_aligned = {bus.req_wdata[7:0], 24'h0};
            SIZE_HALF: w_wdata_aligned = {bus.req_wdata[15:0], 16'h0};
            default:   w_wdata_aligned = bus.req_wdata;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_bad)          w_state_next = ST_RESP;
                    else if (SKIP_WAIT) w_state_next = ST_XFER;
                    else                w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) w_state_next = ST_XFER;
            end
            ST_XFER: begin
                // A reset landing on this edge must not commit the pending byte.
                w_mem_we = r_write & i_reset;
                if (r_byte_cnt == r_last) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_write     <= 1'b0;
            r_last      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_wait_cnt  <= 4'd0;
            r_byte_cnt  <= 2'd0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write    <= bus.req_write;
                        r_last     <= 2'(bytes_for_size(bus.req_size) - 3'd1);
                        r_addr     <= bus.req_addr;
                        r_wdata    <= w_wdata_aligned;
                        r_rdata    <= '0;
                        r_wait_cnt <= 4'(WAIT_CYCLES - 1);
                        r_byte_cnt <= 2'd0;
                        r_err      <= w_bad;
                    end
                end
                ST_WAIT: r_wait_cnt <= r_wait_cnt - 4'd1;
                ST_XFER: begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_write) r_wdata <= {r_wdata[DATA_WIDTH-9:0], 8'h0};
                    else         r_rdata <= {r_rdata[DATA_WIDTH-9:0], w_mem_rdata};
                end
                ST_RESP: begin
                    // Response registers settle for one cycle before being presented.
                    if (!r_rsp_valid)        r_rsp_valid <= 1'b1;
                    else if (bus.rsp_ready)  r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mem_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .i_clock (i_clock),
        .i_we    (w_mem_we),
        .i_addr  (w_xfer_addr),
        .i_wdata (r_wdata[DATA_WIDTH-1 -: 8]),
        .o_rdata (w_mem_rdata)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_valid ? r_rdata : '0;
    assign bus.rsp_err   = r_rsp_valid & r_err;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a WAIT_CYCLES=1 and a WAIT_CYCLES=0 instance share one stimulus bus.
module tb_memory_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus1 ();
    memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();

    assign bus1.req_valid = req_valid & ~sel;
    assign bus0.req_valid = req_valid & sel;
    assign bus1.req_write = req_write;
    assign bus0.req_write = req_write;
    assign bus1.req_size  = req_size;
    assign bus0.req_size  = req_size;
    assign bus1.req_addr  = req_addr;
    assign bus0.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;
    assign bus0.req_wdata = req_wdata;
    assign bus1.rsp_ready = rsp_ready;
    assign bus0.rsp_ready = rsp_ready;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    assign m_req_ready = sel ? bus0.req_ready : bus1.req_ready;
    assign m_rsp_valid = sel ? bus0.rsp_valid : bus1.rsp_valid;
    assign m_rsp_err   = sel ? bus0.rsp_err   : bus1.rsp_err;
    assign m_rsp_rdata = sel ? bus0.rsp_rdata : bus1.rsp_rdata;

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut1 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus1)
    );

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus0)
    );

    typedef struct {
        logic        sel;
        logic        wr;
        logic [1:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, measure latency, then take the response.
    task automatic do_req(input string name, input logic w, input logic [1:0] s, input logic [7:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_size  = s;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        n = 0;
        while (!m_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " req_ready"}, 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_size  = s ^ 2'b01;
        req_addr  = ~a;
        req_wdata = ~d;
        lat = 0;
        while (!m_rsp_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        rd = m_rsp_rdata;
        e  = m_rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;

        sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_size = SIZE_BYTE; req_addr = 8'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(m_req_ready), 32'd1);
        check("reset rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("reset rsp_rdata", m_rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(m_rsp_err), 32'd0);
        check("reset dut0 req_ready", 32'(bus0.req_ready), 32'd1);
        rst_n = 1'b1;

        //             sel wr  size       addr   wdata          rdata          err lat
        vecs.push_back('{0, 1, SIZE_WORD, 8'h10, 32'hDEADBEEF, 32'h00000000, 0, 6});
        vecs.push_back('{0, 0, SIZE_WORD, 8'h10, 32'h0,        32'hDEADBEEF, 0, 6});
        vecs.push_back('{0, 0, SIZE_BYTE, 8'h11, 32'h0,        32'h000000AD, 0, 3});
        vecs.push_back('{0, 1, SIZE_WORD, 8'h20, 32'h00000000, 32'h00000000, 0, 6});
        vecs.push_back('{0, 1, SIZE_HALF, 8'h22, 32'h00001234, 32'h00000000, 0, 4});
        vecs.push_back('{0, 0, SIZE_WORD, 8'h20, 32'h0,        32'h00001234, 0, 6});
        vecs.push_back('{0, 0, SIZE_WORD, 8'h13, 32'h0,        32'h00000000, 1, 1});
        vecs.push_back('{0, 1, SIZE_HALF, 8'h21, 32'h0000FFFF, 32'h00000000, 1, 1});
        vecs.push_back('{0, 1, SIZE_RSVD, 8'h20, 32'hFFFFFFFF, 32'h00000000, 1, 1});
        vecs.push_back('{0, 0, SIZE_WORD, 8'h20, 32'h0,        32'h00001234, 0, 6});
        vecs.push_back('{0, 0, SIZE_HALF, 8'h10, 32'h0,        32'h0000DEAD, 0, 4});
        vecs.push_back('{0, 1, SIZE_BYTE, 8'h12, 32'hFFFFFF5A, 32'h00000000, 0, 3});
        vecs.push_back('{0, 0, SIZE_WORD, 8'h10, 32'h0,        32'hDEAD5AEF, 0, 6});
        vecs.push_back('{0, 1, SIZE_WORD, 8'h30, 32'h01020304, 32'h00000000, 0, 6});
        vecs.push_back('{0, 1, SIZE_WORD, 8'hFC, 32'h11223344, 32'h00000000, 0, 6});
        vecs.push_back('{1, 1, SIZE_BYTE, 8'hFF, 32'h00000077, 32'h00000000, 0, 2});
        vecs.push_back('{1, 1, SIZE_BYTE, 8'h00, 32'h00000088, 32'h00000000, 0, 2});
        vecs.push_back('{1, 0, SIZE_BYTE, 8'hFF, 32'h0,        32'h00000077, 0, 2});
        vecs.push_back('{1, 0, SIZE_BYTE, 8'h00, 32'h0,        32'h00000088, 0, 2});
        vecs.push_back('{1, 1, SIZE_WORD, 8'hFC, 32'h01020304, 32'h00000000, 0, 5});
        vecs.push_back('{1, 0, SIZE_BYTE, 8'hFF, 32'h0,        32'h00000004, 0, 2});
        vecs.push_back('{1, 0, SIZE_BYTE, 8'h00, 32'h0,        32'h00000088, 0, 2});
        vecs.push_back('{1, 0, SIZE_HALF, 8'hFE, 32'h0,        32'h00000304, 0, 3});
        vecs.push_back('{1, 0, SIZE_WORD, 8'hFE, 32'h0,        32'h00000000, 1, 1});

        foreach (vecs[i]) begin
            @(negedge clk);
            sel = vecs[i].sel;
            do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, e, lat);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Stalled response with a competing request pending.
        @(negedge clk);
        sel = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD; req_addr = 8'h30; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!m_rsp_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("stall latency", 32'(lat), 32'd6);
        req_valid = 1'b1; req_size = SIZE_BYTE; req_addr = 8'h31;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d rsp_valid", k), 32'(m_rsp_valid), 32'd1);
            check($sformatf("stall%0d rdata", k), m_rsp_rdata, 32'h01020304);
            check($sformatf("stall%0d req_ready", k), 32'(m_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("handshake req_ready", 32'(m_req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("next accepted req_ready", 32'(m_req_ready), 32'd0);
        req_valid = 1'b0;
        lat = 0;
        while (!m_rsp_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("next latency", 32'(lat), 32'd3);
        check("next rdata", m_rsp_rdata, 32'h00000002);
        @(posedge clk);
        #1;

        // Reset during a word write: bytes at 0xFC/0xFD commit, 0xFE/0xFF keep old data.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_addr = 8'hFC; req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("abort req_ready", 32'(m_req_ready), 32'd1);
        check("abort rdata", m_rsp_rdata, 32'd0);
        check("abort err", 32'(m_rsp_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort no response", 32'(m_rsp_valid), 32'd0);
        do_req("after abort", 1'b0, SIZE_WORD, 8'hFC, 32'h0, rd, e, lat);
        check("after abort rdata", rd, 32'hAABB3344);
        check("after abort err", 32'(e), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
